ysyx_24100027_ifu: RTL and testbench

// - Instruction fetch unit: owns the PC, fetches over a valid/ready imem port, hands one

---
 rtl/ysyx_24100027_ifu_if.sv | 25 ++
 rtl/ysyx_24100027_ifu.sv | 123 ++++++++++++
 tb/tb_ysyx_24100027_ifu.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100027_ifu_if.sv
// Fetch-side bus bundle: imem request/response channel plus the decode handoff.
interface ysyx_24100027_ifu_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            imem_resp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready
  );
endinterface

// File: rtl/ysyx_24100027_ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time and
// computes the next PC from the branch selects when execute commits.
//
// state   | meaning
// S_REQ   | imem request offered at pc
// S_RESP  | waiting for imem response
// S_ISSUE | instruction offered to decode
// S_EXEC  | waiting for commit from execute
// S_FAULT | sticky fault, no further fetches
module ysyx_24100027_ifu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_a_sel_i,
  input  logic                   pc_b_sel_i,
  input  logic [XLEN-1:0]        imm_i,
  input  logic [XLEN-1:0]        rs1_data_i,
  input  logic                   commit_i,
  ysyx_24100027_ifu_if.master    bus,
  output logic                   fetch_fault_o,
  output logic [31:0]            retire_cnt_o
);

  localparam logic [2:0] S_REQ   = 3'd0;
  localparam logic [2:0] S_RESP  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            run_q;

  logic [XLEN-1:0] addend;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] next_pc;

  always_comb begin
    addend  = pc_a_sel_i ? imm_i : XLEN'(4);
    base    = pc_b_sel_i ? rs1_data_i : pc_q;
    sum     = addend + base;
    // JALR targets always have bit 0 cleared
    next_pc = pc_b_sel_i ? {sum[XLEN-1:1], 1'b0} : sum;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_REQ: begin
        if (run_q && bus.imem_req_ready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.imem_resp_valid) begin
          if (bus.imem_resp_err) begin
            state_d = S_FAULT;
          end else begin
            inst_d    = bus.imem_resp_data;
            inst_pc_d = pc_q;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (bus.inst_ready) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (commit_i) begin
          cnt_d = cnt_q + 32'd1;
          if (next_pc[1]) begin
            state_d = S_FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // run_q holds requests off until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      inst_pc_q <= RESET_PC;
      cnt_q     <= 32'd0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      cnt_q     <= cnt_d;
      run_q     <= 1'b1;
    end
  end

  assign bus.imem_req_valid = run_q && (state_q == S_REQ);
  assign bus.imem_addr      = pc_q;
  assign bus.inst_valid     = (state_q == S_ISSUE);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign fetch_fault_o      = (state_q == S_FAULT);
  assign retire_cnt_o       = cnt_q;

endmodule

// File: tb/tb_ysyx_24100027_ifu.sv
// Directed bench for the fetch unit: a table of commit vectors plus
// hand-written reset, backpressure and fault sequences.
module tb_ysyx_24100027_ifu;

  logic        clk;
  logic        rst_n;
  logic        pc_a_sel;
  logic        pc_b_sel;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        commit;
  logic        fetch_fault;
  logic [31:0] retire_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int req_hs  = 0;
  int iss_hs  = 0;

  ysyx_24100027_ifu_if #(.XLEN(32)) bus ();

  ysyx_24100027_ifu #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_a_sel_i   (pc_a_sel),
    .pc_b_sel_i   (pc_b_sel),
    .imm_i        (imm),
    .rs1_data_i   (rs1_data),
    .commit_i     (commit),
    .bus          (bus.master),
    .fetch_fault_o(fetch_fault),
    .retire_cnt_o (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && bus.imem_req_valid && bus.imem_req_ready) req_hs++;
    if (rst_n && bus.inst_valid && bus.inst_ready) iss_hs++;
  end

  typedef struct {
    logic        a;
    logic        b;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] pc;
    logic [31:0] exp_next;
    logic        exp_fault;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'd0;
    bus.imem_resp_err   = 1'b0;
    bus.inst_ready      = 1'b0;
    commit   = 1'b0;
    pc_a_sel = 1'b0;
    pc_b_sel = 1'b0;
    imm      = 32'd0;
    rs1_data = 32'd0;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20 && !bus.imem_req_valid; k++) @(negedge clk);
    chk("req_wait", {31'd0, bus.imem_req_valid}, 32'd1);
  endtask

  // request -> response -> issue, leaves the DUT waiting for commit
  task automatic fetch_issue(input logic [31:0] exp_pc, input logic [31:0] data);
    wait_req();
    chk("req_addr", bus.imem_addr, exp_pc);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = data;
    @(negedge clk);
    bus.imem_resp_valid = 1'b0;
    chk("inst_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("inst", bus.inst, data);
    chk("inst_pc", bus.inst_pc, exp_pc);
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
  endtask

  task automatic do_commit(input logic a, input logic b, input logic [31:0] im,
                           input logic [31:0] r1);
    pc_a_sel = a;
    pc_b_sel = b;
    imm      = im;
    rs1_data = r1;
    commit   = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h8000_0000);
    rst_n = 1'b1;
    #1;
    chk("rel_req_valid_before_edge", {31'd0, bus.imem_req_valid}, 32'd0);
    @(negedge clk);
    chk("rel_req_valid_first_cycle", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("rel_addr", bus.imem_addr, 32'h8000_0000);
  endtask

  initial begin
    logic [31:0] held;
    logic        saw_req;

    //        a     b     imm            rs1            pc             next           flt   cnt
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0004, 1'b0, 32'd1};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h8000_0004, 32'h8000_0008, 1'b0, 32'd2};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h8000_0008, 32'h8000_0010, 1'b0, 32'd3};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0000_0000, 32'h8000_0010, 32'h8000_0008, 1'b0, 32'd4};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0004, 32'h8000_1001, 32'h8000_0008, 32'h8000_1004, 1'b0, 32'd5};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0000, 32'h8000_2000, 32'h8000_1004, 32'h8000_2004, 1'b0, 32'd6};
    vecs[6] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_2004, 32'h8000_0000, 1'b0, 32'd7};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 32'h8000_0000, 32'h0000_0000, 1'b0, 32'd8};
    vecs[8] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 1'b0, 32'd9};
    vecs[9] = '{1'b1, 1'b0, 32'h0000_0002, 32'h0000_0000, 32'h0000_0004, 32'h0000_0004, 1'b1, 32'd10};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      fetch_issue(vecs[i].pc, 32'h0000_0013 + i);
      do_commit(vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].rs1);
      chk($sformatf("v%0d_cnt", i), retire_cnt, vecs[i].exp_cnt);
      chk($sformatf("v%0d_fault", i), {31'd0, fetch_fault}, {31'd0, vecs[i].exp_fault});
      chk($sformatf("v%0d_req_valid", i), {31'd0, bus.imem_req_valid},
          {31'd0, ~vecs[i].exp_fault});
      chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].exp_next);
    end

    // in fault: no requests, no issue, commit ignored
    saw_req = 1'b0;
    bus.imem_req_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (bus.imem_req_valid || bus.inst_valid) saw_req = 1'b1;
      @(negedge clk);
    end
    bus.imem_req_ready = 1'b0;
    chk("fault_no_req", {31'd0, saw_req}, 32'd0);
    do_commit(1'b0, 1'b0, 32'd0, 32'd0);
    chk("fault_commit_cnt", retire_cnt, 32'd10);
    chk("fault_commit_pc", bus.imem_addr, 32'h0000_0004);
    chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);

    // backpressure sequence from a fresh reset
    do_reset();
    req_hs = 0;
    iss_hs = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      chk($sformatf("bp_req_hold%0d", k), {31'd0, bus.imem_req_valid}, 32'd1);
      chk($sformatf("bp_addr_hold%0d", k), bus.imem_addr, 32'h8000_0000);
    end
    chk("bp_commit_in_req", retire_cnt, 32'd0);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp_resp_wait", {31'd0, bus.inst_valid}, 32'd0);
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h0010_0093;
    @(negedge clk);
    bus.imem_resp_valid = 1'b0;
    held = bus.inst;
    chk("bp_inst", held, 32'h0010_0093);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hDEAD_BEEF;
        commit = 1'b1;
      end
      @(negedge clk);
      bus.imem_resp_valid = 1'b0;
      commit = 1'b0;
      chk($sformatf("bp_issue_hold%0d", k), {31'd0, bus.inst_valid}, 32'd1);
      chk($sformatf("bp_inst_hold%0d", k), bus.inst, 32'h0010_0093);
    end
    chk("bp_commit_in_issue", retire_cnt, 32'd0);
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    chk("bp_issue_done", {31'd0, bus.inst_valid}, 32'd0);
    chk("bp_req_count", req_hs, 32'd1);
    chk("bp_issue_count", iss_hs, 32'd1);
    do_commit(1'b0, 1'b0, 32'd0, 32'd0);
    chk("lat_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("lat_addr", bus.imem_addr, 32'h8000_0004);
    chk("lat_cnt", retire_cnt, 32'd1);

    // access error on the response
    wait_req();
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_err   = 1'b1;
    @(negedge clk);
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_err   = 1'b0;
    chk("err_fault", {31'd0, fetch_fault}, 32'd1);
    chk("err_no_issue", {31'd0, bus.inst_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("err_no_req", {31'd0, bus.imem_req_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
